// File: rtl/telemetry_sampler.sv
// Holds live telemetry channels stable for whole multi-frame windows, sampling or peak-holding each channel.
// Commit-cycle raw value visible one cycle later; no backpressure, freeze defers publication to the next unfrozen commit.
module telemetry_sampler #(
   parameter int                     NUM_SIGNALS   = 7,
   parameter int                     VALUE_WIDTH   = 9,
   parameter int                     UPDATE_FRAMES = 15,
   parameter logic [NUM_SIGNALS-1:0] PEAK_MASK     = '0,
   localparam int                    CW            = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic                   freeze,
   input  logic [VALUE_WIDTH-1:0] raw_values       [NUM_SIGNALS],
   output logic [VALUE_WIDTH-1:0] telemetry_values [NUM_SIGNALS],
   output logic                   update_pulse,
   output logic [CW-1:0]          window_pos
);

   localparam logic [CW-1:0] LAST_FRAME = CW'(UPDATE_FRAMES - 1);

   logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
   logic [VALUE_WIDTH-1:0] peak_acc_q [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] peak_acc_d [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] tel_q      [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] tel_d      [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] running    [NUM_SIGNALS];
   logic                   pulse_q, pulse_d;
   logic                   commit;
   logic                   publish;

   always_comb begin
      commit      = frame_start && (frame_cnt_q == LAST_FRAME);
      publish     = commit && !freeze;
      pulse_d     = publish;
      frame_cnt_d = frame_cnt_q;
      if (frame_start) begin
         frame_cnt_d = commit ? '0 : frame_cnt_q + CW'(1);
      end
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         running[i]    = (raw_values[i] > peak_acc_q[i]) ? raw_values[i] : peak_acc_q[i];
         peak_acc_d[i] = '0;
         tel_d[i]      = tel_q[i];
         if (PEAK_MASK[i]) begin
            // A frozen commit keeps accumulating so the window stretches to the next published one.
            if (publish) begin
               tel_d[i] = running[i];
            end else begin
               peak_acc_d[i] = running[i];
            end
         end else if (publish) begin
            tel_d[i] = raw_values[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt_q <= '0;
         pulse_q     <= 1'b0;
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            peak_acc_q[i] <= '0;
            tel_q[i]      <= '0;
         end
      end else begin
         frame_cnt_q <= frame_cnt_d;
         pulse_q     <= pulse_d;
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            peak_acc_q[i] <= peak_acc_d[i];
            tel_q[i]      <= tel_d[i];
         end
      end
   end

   assign telemetry_values = tel_q;
   assign update_pulse     = pulse_q;
   assign window_pos       = frame_cnt_q;

endmodule

// File: tb/tb_telemetry_sampler.sv
// Bench for telemetry_sampler: a 3-frame-window instance and a 1-frame-window instance against a window-level model.
module tb_telemetry_sampler;

   localparam int N = 7;
   localparam int W = 9;

   logic         clk = 1'b0;
   logic         reset;
   logic         freeze;
   logic         fs3, fs1;
   logic [W-1:0] raw3 [N];
   logic [W-1:0] raw1 [N];
   logic [W-1:0] tel3 [N];
   logic [W-1:0] tel1 [N];
   logic         upd3, upd1;
   logic [1:0]   wp3;
   logic         wp1;

   int checks = 0;
   int errors = 0;

   // Model state: total frame_starts since reset, running max since last publish, shown values.
   int           frames3, frames1;
   logic [W-1:0] wmax3 [N];
   logic [W-1:0] wmax1 [N];
   logic [W-1:0] shown3 [N];
   logic [W-1:0] shown1 [N];
   logic         exp_pulse3, exp_pulse1;
   logic [N-1:0] mask3, mask1;

   telemetry_sampler #(.NUM_SIGNALS(N), .VALUE_WIDTH(W), .UPDATE_FRAMES(3), .PEAK_MASK(7'b0100110)) dut3 (
      .clk(clk), .reset(reset), .frame_start(fs3), .freeze(freeze), .raw_values(raw3),
      .telemetry_values(tel3), .update_pulse(upd3), .window_pos(wp3));

   telemetry_sampler #(.NUM_SIGNALS(N), .VALUE_WIDTH(W), .UPDATE_FRAMES(1), .PEAK_MASK(7'b1000001)) dut1 (
      .clk(clk), .reset(reset), .frame_start(fs1), .freeze(freeze), .raw_values(raw1),
      .telemetry_values(tel1), .update_pulse(upd1), .window_pos(wp1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      frames3 = 0; frames1 = 0;
      exp_pulse3 = 1'b0; exp_pulse1 = 1'b0;
      for (int i = 0; i < N; i++) begin
         wmax3[i] = '0; wmax1[i] = '0; shown3[i] = '0; shown1[i] = '0;
      end
   endtask

   task automatic model_edge();
      logic c3, c1;
      c3 = 1'b0; c1 = 1'b0;
      if (fs3) begin frames3++; c3 = (frames3 % 3 == 0); end
      if (fs1) begin frames1++; c1 = 1'b1; end
      exp_pulse3 = c3 && !freeze;
      exp_pulse1 = c1 && !freeze;
      for (int i = 0; i < N; i++) begin
         if (raw3[i] > wmax3[i]) wmax3[i] = raw3[i];
         if (raw1[i] > wmax1[i]) wmax1[i] = raw1[i];
         if (exp_pulse3) begin
            shown3[i] = mask3[i] ? wmax3[i] : raw3[i];
            wmax3[i]  = '0;
         end
         if (exp_pulse1) begin
            shown1[i] = mask1[i] ? wmax1[i] : raw1[i];
            wmax1[i]  = '0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("d3_tel%0d", i), 32'(tel3[i]), 32'(shown3[i]));
         chk($sformatf("d1_tel%0d", i), 32'(tel1[i]), 32'(shown1[i]));
      end
      chk("d3_pulse", 32'(upd3), 32'(exp_pulse3));
      chk("d1_pulse", 32'(upd1), 32'(exp_pulse1));
      chk("d3_wpos", 32'(wp3), 32'(frames3 % 3));
      chk("d1_wpos", 32'(wp1), 32'd0);
   endtask

   task automatic cyc(input logic f3, input logic f1);
      fs3 = f3;
      fs1 = f1;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
   endtask

   initial begin
      mask3 = 7'b0100110;
      mask1 = 7'b1000001;
      reset = 1'b0; freeze = 1'b0; fs3 = 1'b0; fs1 = 1'b0;
      for (int i = 0; i < N; i++) begin raw3[i] = '0; raw1[i] = '0; end
      model_reset();
      #2;
      check_all();
      #10 reset = 1'b1;

      // Sample channel 0: value at the third frame_start is published one cycle later.
      raw3[0] = 9'd5;
      cyc(1, 0); idle(2); cyc(1, 0);
      raw3[0] = 9'd9;
      idle(1);
      chk("tp1_before", 32'(tel3[0]), 32'd0);
      cyc(1, 0);
      chk("tp1_val", 32'(tel3[0]), 32'd9);
      chk("tp1_pulse", 32'(upd3), 32'd1);
      idle(1);
      chk("tp1_pulse_once", 32'(upd3), 32'd0);

      // Peak channel 1: mid-window spike wins, then a flat window after clearing.
      raw3[1] = 9'd2;  cyc(1, 0); idle(1);
      raw3[1] = 9'd10; idle(1);
      raw3[1] = 9'd2;  cyc(1, 0); idle(1);
      raw3[1] = 9'd4;  cyc(1, 0);
      chk("tp2_spike", 32'(tel3[1]), 32'd10);
      raw3[1] = 9'd3;  cyc(1, 0); cyc(1, 0); cyc(1, 0);
      chk("tp2_flat", 32'(tel3[1]), 32'd3);

      // Commit-cycle raw value exceeds the accumulated peak.
      raw3[1] = 9'd50;  cyc(1, 0);
      raw3[1] = 9'd20;  cyc(1, 0);
      raw3[1] = 9'd200; cyc(1, 0);
      chk("tp3_commit_raw", 32'(tel3[1]), 32'd200);

      // Frozen commit holds the display; the next window keeps the frozen spike.
      raw3[1] = 9'd5;   cyc(1, 0);
      raw3[1] = 9'd150; idle(1);
      raw3[1] = 9'd5;   cyc(1, 0);
      raw3[0] = 9'd77;  freeze = 1'b1; cyc(1, 0);
      chk("tp4_frozen", 32'(tel3[0]), 32'd9);
      chk("tp4_nopulse", 32'(upd3), 32'd0);
      freeze = 1'b0; cyc(1, 0);
      freeze = 1'b1; idle(1);
      freeze = 1'b0; cyc(1, 0);
      raw3[1] = 9'd6; raw3[0] = 9'd12; cyc(1, 0);
      chk("tp4_peak_kept", 32'(tel3[1]), 32'd150);
      chk("tp4_sample", 32'(tel3[0]), 32'd12);
      chk("tp4_pulse", 32'(upd3), 32'd1);

      // Asynchronous reset at window_pos 2 with nonzero outputs.
      cyc(1, 0); cyc(1, 0);
      chk("tp5_pos2", 32'(wp3), 32'd2);
      #2 reset = 1'b0;
      #1;
      chk("tp5_async_tel", 32'(tel3[1]), 32'd0);
      chk("tp5_async_pos", 32'(wp3), 32'd0);
      model_reset();
      check_all();
      #3 reset = 1'b1;
      cyc(1, 0); cyc(1, 0);
      chk("tp5_no_early", 32'(upd3), 32'd0);
      cyc(1, 0);
      chk("tp5_first_commit", 32'(upd3), 32'd1);

      // One-frame windows: every frame_start commits, max value intact.
      for (int i = 0; i < N; i++) raw1[i] = 9'd511;
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1);
         chk("tp6_val", 32'(tel1[0]), 32'd511);
         chk("tp6_pulse", 32'(upd1), 32'd1);
      end
      idle(1);

      // Randomized traffic on both instances.
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++) begin
            raw3[i] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 511)) : W'($urandom_range(0, 60));
            raw1[i] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 511)) : W'($urandom_range(0, 60));
         end
         if ($urandom_range(0, 9) == 0) freeze = ~freeze;
         cyc(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/telemetry_sampler.md
Name: telemetry_sampler

Overview:
- Sits directly upstream of the telemetry text overlay and produces its per-row value array.
- Captures live game/debug signals and holds them stable for whole update windows (an integer number of video frames), so rendered digits never change mid-frame and stay readable.
- Per channel, either samples the instantaneous value at the window boundary or reports the peak value seen during the window.

Parameters:
- NUM_SIGNALS, 7: number of telemetry channels (rows).
- VALUE_WIDTH, 9: bit width of each channel value.
- UPDATE_FRAMES, 15: frames per update window (≥1; 15 gives ~4 Hz at 60 Hz).
- PEAK_MASK, 0: NUM_SIGNALS-bit mask; bit i=1 makes channel i PEAK mode, 0 makes it SAMPLE mode.

Ports:
- clk  input  1  pixel/system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion assumed synchronised externally.
- frame_start  input  1  one-cycle pulse at start of each frame (from VGA controller, e.g. first blanking line).
- freeze  input  1  level; 1 holds displayed values (debug pause).
- raw_values  input  VALUE_WIDTH x NUM_SIGNALS (unpacked array)  live signals to monitor.
- telemetry_values  output  VALUE_WIDTH x NUM_SIGNALS (unpacked array)  registered held values, drives overlay.
- update_pulse  output  1  one-cycle pulse in the cycle after telemetry_values changes.
- window_pos  output  clog2(UPDATE_FRAMES) min 1  current frame index within window, 0..UPDATE_FRAMES-1.

Behaviour:
- Reset (reset=0, async): telemetry_values all 0, peak_acc all 0, frame_cnt 0, update_pulse 0, window_pos 0.
- frame_cnt:
  - Increments on each frame_start.
  - Wraps to 0 on a frame_start when frame_cnt == UPDATE_FRAMES-1; that frame_start is the commit event.
  - UPDATE_FRAMES=1: every frame_start is a commit.
  - window_pos = frame_cnt.
  - frame_cnt runs regardless of freeze.
- Peak accumulation:
  - Every cycle that is not a commit, for PEAK channels: peak_acc[i] <= max(peak_acc[i], raw_values[i]), unsigned compare.
  - SAMPLE channels keep no accumulator (tie to 0).
- Commit with freeze=0:
  - PEAK channel i: telemetry_values[i] <= max(peak_acc[i], raw_values[i]).
  - SAMPLE channel i: telemetry_values[i] <= raw_values[i].
  - All peak_acc cleared to 0; the commit-cycle raw value belongs to the closing window only.
  - update_pulse <= 1 for exactly the next cycle, i.e. the first cycle new values are visible.
- Commit with freeze=1:
  - telemetry_values unchanged, no update_pulse.
  - peak_acc is not cleared but is updated with the max that includes the commit-cycle raw value, so the window extends until the first unfrozen commit.
- freeze changing mid-window has no effect except at commit.
- Latency: raw value present in a commit cycle appears on telemetry_values 1 cycle later.
- frame_start is sampled only as a 1-cycle pulse. If held high, each cycle counts as a separate frame; this is a caller error and not protected.
- Reset asserted mid-window: all state returns to reset values immediately. The first commit after release occurs on the UPDATE_FRAMES-th frame_start.
- Widths:
  - Values are unsigned, no arithmetic beyond compare, no overflow possible.
  - frame_cnt width is clog2(UPDATE_FRAMES), minimum 1 bit.

Test Plan:
- Reset then UPDATE_FRAMES=3, SAMPLE ch0, raw=5 then 9 before 3rd frame_start -> telemetry_values[0]=9 one cycle after 3rd frame_start; update_pulse high that single cycle; 0 before.
- PEAK ch1, raw 10 for one cycle mid-window, otherwise 2, commit with raw=4 -> output 10; next window constant 3 -> output 4? No: peak cleared, window all 3, commit raw 3 -> output 3.
- PEAK ch1, commit-cycle raw=200 with accumulated max 50 -> output 200.
- freeze=1 across one commit with ch0 raw=77 (prev shown 9) -> stays 9, no update_pulse; freeze=0 at next commit, PEAK ch1 spike 150 in frozen window -> ch1 shows 150.
- Assert reset=0 asynchronously at window_pos=2 with outputs nonzero -> outputs, window_pos, update_pulse all 0 without a clock edge; first commit after exactly UPDATE_FRAMES frame_starts.
- UPDATE_FRAMES=1, raw=511 (max 9-bit) -> committed on every frame_start, value 511 exact, window_pos always 0.
